calc2_port_engine: RTL and testbench

- Single-port calc2 responder. Accepts the two-cycle command/operand request protocol (cmd + tag + operand1, then operand2) and executes add/sub/shl/shr.
- Returns one response per request, in order, with the tag echoed.
- Instantiated once per requester port beneath calc2_top. Its port behaviour is what the calc2 benches drive and check.

---
 rtl/calc2_pkg.sv | 37 +++
 rtl/calc2_req_fifo.sv | 50 +++++
 rtl/calc2_port_engine.sv | 203 ++++++++++++++++++++
 tb/tb_calc2_port_engine.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc2_pkg.sv
// Shared types and constants for the calc2 request/response engines.
// Contents: command and response encodings, the queued request entry, data/tag widths, and a
// logical shift helper used by the execute unit.
package calc2_pkg;

  localparam int unsigned CALC2_DATA_W = 32;
  localparam int unsigned CALC2_TAG_W  = 2;

  typedef enum logic [3:0] {
    NOP = 4'd0,
    ADD = 4'd1,
    SUB = 4'd2,
    SHL = 4'd5,
    SHR = 4'd6
  } cmd_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    OK   = 2'd1,
    ERR  = 2'd2
  } resp_e;

  // cmd is kept as raw bits so invalid codes survive the queue and are rejected at execute.
  typedef struct packed {
    logic [3:0]              cmd;
    logic [CALC2_TAG_W-1:0]  tag;
    logic [CALC2_DATA_W-1:0] op1;
    logic [CALC2_DATA_W-1:0] op2;
  } req_entry_t;

  function automatic logic [CALC2_DATA_W-1:0] calc2_shift(input logic [CALC2_DATA_W-1:0] val,
                                                          input logic                    left,
                                                          input logic [4:0]              amt);
    return left ? (val << amt) : (val >> amt);
  endfunction

endpackage

// File: rtl/calc2_req_fifo.sv
// Synchronous FIFO of captured calc2 requests.
// Ports: clk_i/rst_i (synchronous, active-high), push_i/wdata_i write side, pop_i/rdata_o
// read side (rdata_o shows the head combinationally), full_o/empty_o flags, cnt_o occupancy.
// The caller only raises push_i when the write can land, which includes full with pop_i set.
module calc2_req_fifo
  import calc2_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  req_entry_t             wdata_i,
  output req_entry_t             rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] cnt_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned CntW  = AddrW + 1;

  req_entry_t       mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      cnt_q <= cnt_q + CntW'(push_i) - CntW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/calc2_port_engine.sv
// Single-port calc2 responder: captures two-cycle requests (cmd/tag/op1, then op2), queues them,
// executes add/sub/shl/shr in order and returns one registered response per accepted request.
// Ports: c_clk, reset (synchronous, active-high); req_cmd_in/req_data_in/req_tag_in request
// side; out_resp/out_data/out_tag one-cycle response; busy (queue or execute active);
// overrun (sticky, a request was dropped on a full queue).
module calc2_port_engine
  import calc2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SHIFT_STEP = 8
) (
  input  logic                    c_clk,
  input  logic                    reset,
  input  logic [3:0]              req_cmd_in,
  input  logic [CALC2_DATA_W-1:0] req_data_in,
  input  logic [CALC2_TAG_W-1:0]  req_tag_in,
  output logic [1:0]              out_resp,
  output logic [CALC2_DATA_W-1:0] out_data,
  output logic [CALC2_TAG_W-1:0]  out_tag,
  output logic                    busy,
  output logic                    overrun
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [5:0]  Step = 6'(SHIFT_STEP);

  typedef enum logic {StIdle, StOp2} cap_state_e;
  typedef enum logic {ExIdle, ExShift} ex_state_e;

  cap_state_e              cap_state_q;
  logic [3:0]              cap_cmd_q;
  logic [CALC2_TAG_W-1:0]  cap_tag_q;
  logic [CALC2_DATA_W-1:0] cap_op1_q;

  ex_state_e               ex_state_q;
  logic [CALC2_DATA_W-1:0] sh_val_q;
  logic [4:0]              sh_rem_q;
  logic                    sh_left_q;
  logic [CALC2_TAG_W-1:0]  sh_tag_q;

  resp_e                   out_resp_q;
  logic [CALC2_DATA_W-1:0] out_data_q;
  logic [CALC2_TAG_W-1:0]  out_tag_q;
  logic                    busy_q, overrun_q;

  req_entry_t              new_entry, fifo_head;
  logic                    fifo_full, fifo_empty;
  logic [CntW-1:0]         fifo_cnt, cnt_d;
  logic                    push_req, push_ok, drop, pop;

  logic [4:0]              head_shamt, head_amt, head_rem, sh_amt, sh_rem_next;
  logic                    head_is_shift, head_multi, ex_shift_d, busy_d;
  logic [CALC2_DATA_W:0]   sum;
  resp_e                   head_resp;
  logic [CALC2_DATA_W-1:0] head_data, sh_val_next;

  // Capture FSM: command cycle latches cmd/tag/op1; the following cycle supplies op2.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      cap_state_q <= StIdle;
      cap_cmd_q   <= '0;
      cap_tag_q   <= '0;
      cap_op1_q   <= '0;
    end else begin
      case (cap_state_q)
        StIdle: begin
          if (req_cmd_in != 4'd0) begin
            cap_cmd_q   <= req_cmd_in;
            cap_tag_q   <= req_tag_in;
            cap_op1_q   <= req_data_in;
            cap_state_q <= StOp2;
          end
        end
        StOp2:   cap_state_q <= StIdle;
        default: cap_state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    new_entry.cmd = cap_cmd_q;
    new_entry.tag = cap_tag_q;
    new_entry.op1 = cap_op1_q;
    new_entry.op2 = req_data_in;
    push_req      = (cap_state_q == StOp2);
    pop           = (ex_state_q == ExIdle) && !fifo_empty;
    // A full queue still takes the push when the head leaves on the same edge.
    push_ok       = push_req && (!fifo_full || pop);
    drop          = push_req && fifo_full && !pop;
  end

  calc2_req_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_req_fifo (
    .clk_i  (c_clk),
    .rst_i  (reset),
    .push_i (push_ok),
    .pop_i  (pop),
    .wdata_i(new_entry),
    .rdata_o(fifo_head),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .cnt_o  (fifo_cnt)
  );

  // Head decode: single-cycle results, and the first shift chunk applied on the pop edge.
  always_comb begin
    head_resp     = ERR;
    head_data     = '0;
    sum           = {1'b0, fifo_head.op1} + {1'b0, fifo_head.op2};
    head_shamt    = fifo_head.op2[4:0];
    head_amt      = ({1'b0, head_shamt} > Step) ? Step[4:0] : head_shamt;
    head_rem      = head_shamt - head_amt;
    head_is_shift = (fifo_head.cmd == SHL) || (fifo_head.cmd == SHR);
    head_multi    = head_is_shift && (head_rem != 5'd0);
    case (fifo_head.cmd)
      ADD: begin
        if (!sum[CALC2_DATA_W]) begin
          head_resp = OK;
          head_data = sum[CALC2_DATA_W-1:0];
        end
      end
      SUB: begin
        if (fifo_head.op2 <= fifo_head.op1) begin
          head_resp = OK;
          head_data = fifo_head.op1 - fifo_head.op2;
        end
      end
      SHL, SHR: begin
        head_resp = OK;
        head_data = calc2_shift(fifo_head.op1, fifo_head.cmd == SHL, head_amt);
      end
      default: ;
    endcase
  end

  always_comb begin
    sh_amt      = ({1'b0, sh_rem_q} > Step) ? Step[4:0] : sh_rem_q;
    sh_rem_next = sh_rem_q - sh_amt;
    sh_val_next = calc2_shift(sh_val_q, sh_left_q, sh_amt);
    ex_shift_d  = ((ex_state_q == ExShift) && (sh_rem_next != 5'd0)) || (pop && head_multi);
    cnt_d       = fifo_cnt + CntW'(push_ok) - CntW'(pop);
    busy_d      = (cnt_d != '0) || ex_shift_d;
  end

  // Execute FSM with registered one-cycle response outputs.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      ex_state_q <= ExIdle;
      sh_val_q   <= '0;
      sh_rem_q   <= '0;
      sh_left_q  <= 1'b0;
      sh_tag_q   <= '0;
      out_resp_q <= NONE;
      out_data_q <= '0;
      out_tag_q  <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      out_resp_q <= NONE;
      out_data_q <= '0;
      out_tag_q  <= '0;
      busy_q     <= busy_d;
      if (drop) overrun_q <= 1'b1;
      case (ex_state_q)
        ExIdle: begin
          if (pop) begin
            if (head_multi) begin
              ex_state_q <= ExShift;
              sh_val_q   <= head_data;
              sh_rem_q   <= head_rem;
              sh_left_q  <= (fifo_head.cmd == SHL);
              sh_tag_q   <= fifo_head.tag;
            end else begin
              out_resp_q <= head_resp;
              out_data_q <= head_data;
              out_tag_q  <= fifo_head.tag;
            end
          end
        end
        ExShift: begin
          if (sh_rem_next == 5'd0) begin
            ex_state_q <= ExIdle;
            out_resp_q <= OK;
            out_data_q <= sh_val_next;
            out_tag_q  <= sh_tag_q;
          end else begin
            sh_val_q <= sh_val_next;
            sh_rem_q <= sh_rem_next;
          end
        end
        default: ex_state_q <= ExIdle;
      endcase
    end
  end

  assign out_resp = out_resp_q;
  assign out_data = out_data_q;
  assign out_tag  = out_tag_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_calc2_port_engine.sv
module tb_calc2_port_engine;

  localparam int Depth = 4;
  localparam int Step  = 8;
  localparam int MaxC  = 8192;

  logic        c_clk = 1'b0;
  logic        reset;
  logic [3:0]  req_cmd_in;
  logic [31:0] req_data_in;
  logic [1:0]  req_tag_in;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic        busy;
  logic        overrun;

  calc2_port_engine #(
    .FIFO_DEPTH(Depth),
    .SHIFT_STEP(Step)
  ) dut (
    .c_clk      (c_clk),
    .reset      (reset),
    .req_cmd_in (req_cmd_in),
    .req_data_in(req_data_in),
    .req_tag_in (req_tag_in),
    .out_resp   (out_resp),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 c_clk = ~c_clk;

  int cyc = 0;
  always @(posedge c_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected outputs after each edge, filled in by the model when requests are accepted.
  bit [1:0]  exp_resp [MaxC];
  bit [31:0] exp_data [MaxC];
  bit [1:0]  exp_tag  [MaxC];
  bit        exp_busy [MaxC];
  bit        exp_ovr  [MaxC];

  bit        cap_pend;
  bit [3:0]  cap_cmd;
  bit [1:0]  cap_tag;
  bit [31:0] cap_op1;
  int        last_c;
  int        pop_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s after edge %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  always @(negedge c_clk) begin
    if (cyc > 0 && cyc < MaxC) begin
      check("resp", 32'(out_resp), 32'(exp_resp[cyc]));
      check("data", out_data, exp_data[cyc]);
      if (exp_resp[cyc] != 2'd0) check("tag", 32'(out_tag), 32'(exp_tag[cyc]));
      check("busy", 32'(busy), 32'(exp_busy[cyc]));
      check("overrun", 32'(overrun), 32'(exp_ovr[cyc]));
    end
  end

  function automatic void model_result(input bit [3:0] cmd, input bit [31:0] a,
                                       input bit [31:0] b, output bit [1:0] resp,
                                       output bit [31:0] data, output int n);
    longint unsigned s;
    int sh;
    sh   = int'(b[4:0]);
    n    = 1;
    resp = 2'd2;
    data = 32'd0;
    case (cmd)
      4'd1: begin
        s = 64'(a) + 64'(b);
        if (s <= 64'hFFFF_FFFF) begin
          resp = 2'd1;
          data = a + b;
        end
      end
      4'd2: if (b <= a) begin
        resp = 2'd1;
        data = a - b;
      end
      4'd5, 4'd6: begin
        resp = 2'd1;
        data = (cmd == 4'd5) ? (a << sh) : (a >> sh);
        n    = (sh == 0) ? 1 : (sh + Step - 1) / Step;
      end
      default: ;
    endcase
  endfunction

  // Request pushed at edge e: dropped if Depth queued entries remain after any pop at e.
  task automatic accept(input int e, input bit [31:0] op2);
    int cnt, s, c, n;
    bit [1:0] resp;
    bit [31:0] data;
    cnt = 0;
    while (pop_q.size() > 0 && pop_q[0] <= e) void'(pop_q.pop_front());
    cnt = pop_q.size();
    if (cnt >= Depth) begin
      if (!exp_ovr[e]) for (int k = e; k < MaxC; k++) exp_ovr[k] = 1'b1;
    end else begin
      s = (e + 1 > last_c + 1) ? e + 1 : last_c + 1;
      model_result(cap_cmd, cap_op1, op2, resp, data, n);
      c = s + n - 1;
      last_c = c;
      pop_q.push_back(s);
      if (c < MaxC) begin
        exp_resp[c] = resp;
        exp_data[c] = data;
        exp_tag[c]  = cap_tag;
      end
      for (int k = e; k < c && k < MaxC; k++) exp_busy[k] = 1'b1;
    end
  endtask

  task automatic tick(input bit [3:0] cmd, input bit [1:0] tag, input bit [31:0] data,
                      input bit rst);
    int e;
    e = cyc + 1;
    req_cmd_in  = cmd;
    req_tag_in  = tag;
    req_data_in = data;
    reset       = rst;
    if (rst) begin
      for (int k = e; k < MaxC; k++) begin
        exp_resp[k] = 2'd0;
        exp_data[k] = 32'd0;
        exp_tag[k]  = 2'd0;
        exp_busy[k] = 1'b0;
        exp_ovr[k]  = 1'b0;
      end
      pop_q.delete();
      cap_pend = 1'b0;
      last_c   = e;
    end else if (cap_pend) begin
      accept(e, data);
      cap_pend = 1'b0;
    end else if (cmd != 4'd0) begin
      cap_pend = 1'b1;
      cap_cmd  = cmd;
      cap_tag  = tag;
      cap_op1  = data;
    end
    @(posedge c_clk);
    @(negedge c_clk);
  endtask

  task automatic idle(input int k);
    repeat (k) tick(4'd0, 2'($urandom), $urandom, 1'b0);
  endtask

  task automatic req(input bit [3:0] cmd, input bit [1:0] tag, input bit [31:0] op1,
                     input bit [31:0] op2);
    tick(cmd, tag, op1, 1'b0);
    tick(4'd0, 2'($urandom), op2, 1'b0);
  endtask

  function automatic bit [31:0] rand_data();
    case ($urandom_range(3))
      0:       return 32'($urandom_range(63));
      1:       return 32'hFFFF_FFFF - 32'($urandom_range(63));
      default: return $urandom;
    endcase
  endfunction

  bit [3:0] cmd_pool [14];

  initial begin
    cmd_pool = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd5, 4'd6, 4'd5, 4'd6, 4'd3,
                 4'd7, 4'd15};
    cap_pend = 1'b0;
    last_c   = 0;
    tick(4'd0, 2'd0, 32'd0, 1'b1);
    tick(4'd0, 2'd0, 32'd0, 1'b1);
    check("reset_resp", 32'(out_resp), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    idle(1);

    req(4'd1, 2'd1, 32'h30, 32'h20);
    idle(1);
    check("add_resp", 32'(out_resp), 32'd1);
    check("add_data", out_data, 32'h50);
    check("add_tag", 32'(out_tag), 32'd1);
    idle(1);
    check("add_resp_clear", 32'(out_resp), 32'd0);

    req(4'd1, 2'd0, 32'hFFFF_FFFF, 32'h1);
    idle(1);
    check("add_ovf_resp", 32'(out_resp), 32'd2);
    check("add_ovf_data", out_data, 32'd0);
    req(4'd2, 2'd3, 32'h5, 32'h6);
    idle(1);
    check("sub_unf_resp", 32'(out_resp), 32'd2);
    req(4'd2, 2'd3, 32'h6, 32'h6);
    idle(1);
    check("sub_eq_resp", 32'(out_resp), 32'd1);
    check("sub_eq_data", out_data, 32'd0);
    req(4'd3, 2'd2, 32'h1234, 32'h5678);
    idle(1);
    check("inv_resp", 32'(out_resp), 32'd2);
    check("inv_tag", 32'(out_tag), 32'd2);

    req(4'd5, 2'd1, 32'h1, 32'd20);
    idle(2);
    check("shl20_early", 32'(out_resp), 32'd0);
    idle(1);
    check("shl20_resp", 32'(out_resp), 32'd1);
    check("shl20_data", out_data, 32'h0010_0000);
    req(4'd6, 2'd2, 32'h8000_0000, 32'h21);
    idle(1);
    check("shr1_data", out_data, 32'h4000_0000);
    req(4'd5, 2'd3, 32'hDEAD_BEEF, 32'h0);
    idle(1);
    check("shl0_resp", 32'(out_resp), 32'd1);
    check("shl0_data", out_data, 32'hDEAD_BEEF);
    idle(2);

    // Back-to-back long shifts until the queue overflows.
    for (int i = 0; i < 40; i++) begin
      req(4'd6, 2'(i), 32'hFFFF_FFFF, 32'd31);
      if (overrun === 1'b1) break;
    end
    check("overrun_set", 32'(overrun), 32'd1);
    idle(40);
    check("overrun_sticky", 32'(overrun), 32'd1);
    check("drained_busy", 32'(busy), 32'd0);

    // Reset while a shift runs with two adds queued behind it.
    req(4'd6, 2'd0, 32'hFFFF_FFFF, 32'd31);
    req(4'd6, 2'd1, 32'hFFFF_FFFF, 32'd31);
    req(4'd1, 2'd2, 32'h1, 32'h1);
    req(4'd1, 2'd3, 32'h2, 32'h2);
    tick(4'd0, 2'd0, 32'd0, 1'b1);
    check("rst_mid_resp", 32'(out_resp), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_ovr", 32'(overrun), 32'd0);
    idle(12);
    req(4'd1, 2'd1, 32'h2, 32'h3);
    idle(1);
    check("post_rst_resp", 32'(out_resp), 32'd1);
    check("post_rst_data", out_data, 32'h5);

    // A command in the operand2 cycle is not a new request.
    tick(4'd1, 2'd3, 32'h100, 1'b0);
    tick(4'd1, 2'd0, 32'h23, 1'b0);
    idle(1);
    check("op2_cmd_resp", 32'(out_resp), 32'd1);
    check("op2_cmd_data", out_data, 32'h123);
    check("op2_cmd_tag", 32'(out_tag), 32'd3);
    idle(6);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(399) == 0) tick(4'd0, 2'd0, 32'd0, 1'b1);
      else tick(cmd_pool[$urandom_range(13)], 2'($urandom), rand_data(), 1'b0);
    end
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
